// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: refills one 4-word cache line over a 32-bit beat bus,
// writing back a dirty victim first.
module cache_refill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_req,
  input  logic [ADDR_W-1:0]          miss_addr,
  input  logic                       wb_dirty,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [32*LINE_WORDS-1:0]   wb_line,
  output logic                       miss_busy,
  output logic                       fill_valid,
  output logic [ADDR_W-1:0]          fill_addr,
  output logic [32*LINE_WORDS-1:0]   fill_line,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  output logic [15:0]                refill_count
);
  typedef enum logic [1:0] {IDLE, WB, FETCH, DONE} state_e;
  state_e state_q, state_d;
  logic [1:0] beat_q, beat_d;
  // Only line indices are stored, so every beat address stays inside its line.
  logic [ADDR_W-5:0] miss_base_q, miss_base_d, wb_base_q, wb_base_d, fill_base_q, fill_base_d;
  logic [32*LINE_WORDS-1:0] wb_line_q, wb_line_d, fill_line_q, fill_line_d;
  logic [15:0] refill_count_q, refill_count_d;
  always_ff @(posedge clk)
    if (!reset) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      miss_base_q    <= '0;
      wb_base_q      <= '0;
      fill_base_q    <= '0;
      wb_line_q      <= '0;
      fill_line_q    <= '0;
      refill_count_q <= '0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      miss_base_q    <= miss_base_d;
      wb_base_q      <= wb_base_d;
      fill_base_q    <= fill_base_d;
      wb_line_q      <= wb_line_d;
      fill_line_q    <= fill_line_d;
      refill_count_q <= refill_count_d;
    end
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    miss_base_d    = miss_base_q;
    wb_base_d      = wb_base_q;
    fill_base_d    = fill_base_q;
    wb_line_d      = wb_line_q;
    fill_line_d    = fill_line_q;
    refill_count_d = refill_count_q;
    case (state_q)
      IDLE: if (miss_req) begin
        state_d     = wb_dirty ? WB : FETCH;
        beat_d      = '0;
        miss_base_d = miss_addr[ADDR_W-1:4];
        wb_base_d   = wb_addr[ADDR_W-1:4];
        wb_line_d   = wb_line;
      end
      WB: if (mem_ack) begin
        beat_d  = beat_q + 2'd1;
        state_d = beat_q == 2'd3 ? FETCH : WB;
      end
      FETCH: begin
        fill_base_d = miss_base_q;
        if (mem_ack) begin
          fill_line_d[{beat_q, 5'd0} +: 32] = mem_rdata;
          beat_d  = beat_q + 2'd1;
          state_d = beat_q == 2'd3 ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d        = IDLE;
        refill_count_d = refill_count_q + {15'd0, ~&refill_count_q};
      end
    endcase
  end
  always_comb begin
    miss_busy  = state_q != IDLE;
    mem_req    = state_q == WB || state_q == FETCH;
    mem_we     = state_q == WB;
    fill_valid = state_q == DONE;
    mem_addr   = state_q == WB ? {wb_base_q, beat_q, 2'b00} :
                 state_q == FETCH ? {miss_base_q, beat_q, 2'b00} : '0;
    mem_wdata  = state_q == WB ? wb_line_q[{beat_q, 5'd0} +: 32] : '0;
  end
  assign fill_addr    = {fill_base_q, 4'h0};
  assign fill_line    = fill_line_q;
  assign refill_count = refill_count_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: scoreboard bench; expected beats and fills are queued at
// issue time and popped as the DUT completes them.
module tb_cache_refill_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic miss_req = 1'b0, wb_dirty = 1'b0, mem_ack = 1'b0;
  logic [31:0] miss_addr = '0, wb_addr = '0, mem_rdata = '0;
  logic [127:0] wb_line = '0;
  logic miss_busy, fill_valid, mem_req, mem_we;
  logic [31:0] fill_addr, mem_addr, mem_wdata;
  logic [127:0] fill_line;
  logic [15:0] refill_count;
  always #5 clk = ~clk;
  cache_refill_ctrl #(.ADDR_W(32), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
    .wb_dirty(wb_dirty), .wb_addr(wb_addr), .wb_line(wb_line),
    .miss_busy(miss_busy), .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_line(fill_line), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .refill_count(refill_count)
  );
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} beat_t;
  typedef struct packed {logic [31:0] addr; logic [127:0] line; logic [31:0] k;} fill_t;
  beat_t exp_beats[$];
  fill_t exp_fills[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, acc_cyc = 0, period = 1;
  logic [31:0] rbase = '0, hold_addr = '0, hold_data = '0, last_fill_addr = '0;
  logic fill_seen = 1'b0, hold = 1'b0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    beat_t b;
    fill_t f;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    mem_ack = ((cyc - acc_cyc + 1) % period) == 0;
    mem_rdata = rbase + {30'd0, mem_addr[3:2]};
    #1;
    if (hold) begin
      check("addr_stable", 128'(mem_addr), 128'(hold_addr));
      check("wdata_stable", 128'(mem_wdata), 128'(hold_data));
    end
    hold = mem_req && !mem_ack;
    hold_addr = mem_addr;
    hold_data = mem_wdata;
    if (mem_req && mem_ack) begin
      if (exp_beats.size() == 0) check("unexpected_beat", 128'(mem_req), 128'(0));
      else begin
        b = exp_beats.pop_front();
        check("beat_we", 128'(mem_we), 128'(b.we));
        check("beat_addr", 128'(mem_addr), 128'(b.addr));
        check("beat_wdata", 128'(mem_wdata), 128'(b.data));
      end
    end
    if (fill_valid) begin
      if (exp_fills.size() == 0) check("unexpected_fill", 128'(fill_valid), 128'(0));
      else begin
        f = exp_fills.pop_front();
        check("fill_addr", 128'(fill_addr), 128'(f.addr));
        check("fill_line", fill_line, f.line);
        check("fill_cycle", 128'(cyc - acc_cyc + 1), 128'(f.k));
        check("fill_busy", 128'(miss_busy), 128'(1));
        last_fill_addr = f.addr;
        fill_seen = 1'b1;
      end
    end
  endtask
  task automatic issue(input logic [31:0] ma, input logic dirty, input logic [31:0] wa,
                       input logic [127:0] wl, input int per, input logic [31:0] rb);
    logic [127:0] fl;
    miss_req = 1'b1;
    miss_addr = ma;
    wb_dirty = dirty;
    wb_addr = wa;
    wb_line = wl;
    period = per;
    rbase = rb;
    acc_cyc = cyc + 1;
    fill_seen = 1'b0;
    if (dirty)
      for (int i = 0; i < 4; i++)
        exp_beats.push_back('{we: 1'b1, addr: {wa[31:4], 4'h0} + 32'(4 * i), data: wl[32*i +: 32]});
    for (int i = 0; i < 4; i++) begin
      exp_beats.push_back('{we: 1'b0, addr: {ma[31:4], 4'h0} + 32'(4 * i), data: 32'd0});
      fl[32*i +: 32] = rb + 32'(i);
    end
    exp_fills.push_back('{addr: {ma[31:4], 4'h0}, line: fl, k: 32'((dirty ? 8 : 4) * per + 1)});
    step();
    miss_req = 1'b0;
    wb_dirty = 1'b0;
  endtask
  task automatic finish_refill(input logic [15:0] exp_cnt);
    for (int n = 0; n < 80 && !fill_seen; n++) step();
    check("fill_seen", 128'(fill_seen), 128'(1));
    step();
    check("busy_after", 128'(miss_busy), 128'(0));
    check("fill_once", 128'(fill_valid), 128'(0));
    check("fill_hold", 128'(fill_addr), 128'(last_fill_addr));
    check("refill_count", 128'(refill_count), 128'(exp_cnt));
    check("beats_left", 128'(exp_beats.size()), 128'(0));
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 128'(miss_busy), 128'(0));
    check({tag, "_fill_valid"}, 128'(fill_valid), 128'(0));
    check({tag, "_mem_req"}, 128'(mem_req), 128'(0));
    check({tag, "_mem_we"}, 128'(mem_we), 128'(0));
    check({tag, "_mem_addr"}, 128'(mem_addr), 128'(0));
    check({tag, "_mem_wdata"}, 128'(mem_wdata), 128'(0));
    check({tag, "_fill_addr"}, 128'(fill_addr), 128'(0));
    check({tag, "_fill_line"}, fill_line, 128'(0));
    check({tag, "_count"}, 128'(refill_count), 128'(0));
  endtask
  initial begin
    repeat (2) step();
    check_all_zero("reset");
    reset = 1'b1;
    step();
    issue(32'h0000_1234, 1'b0, 32'h0, 128'h0, 1, 32'hA0);
    finish_refill(16'd1);
    check("clean_line", fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
    issue(32'h0000_2008, 1'b1, 32'h0000_8000, 128'h00000044_00000033_00000022_00000011, 1, 32'hB0);
    finish_refill(16'd2);
    issue(32'h0000_3004, 1'b0, 32'h0, 128'h0, 3, 32'hC0);
    finish_refill(16'd3);
    issue(32'h0000_4010, 1'b1, 32'h0000_5008, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 2, 32'hD0);
    finish_refill(16'd4);
    issue(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF7, 128'h4_3_2_1, 1, 32'hE0);
    finish_refill(16'd5);
    issue(32'h0000_6000, 1'b0, 32'h0, 128'h0, 1, 32'hF0);
    step();
    miss_req = 1'b1;
    miss_addr = 32'h0000_7000;
    wb_dirty = 1'b1;
    wb_addr = 32'h0000_7100;
    step();
    miss_req = 1'b0;
    wb_dirty = 1'b0;
    finish_refill(16'd6);
    repeat (3) step();
    check("busy_reject_idle", 128'(mem_req), 128'(0));
    issue(32'h0000_9000, 1'b0, 32'h0, 128'h0, 1, 32'h10);
    step();
    step();
    exp_beats.delete();
    exp_fills.delete();
    reset = 1'b0;
    step();
    check_all_zero("abort");
    reset = 1'b1;
    step();
    issue(32'h0000_A000, 1'b1, 32'h0000_B000, 128'h88_77_66_55, 1, 32'h20);
    finish_refill(16'd1);
    force dut.refill_count_q = 16'hFFFE;
    step();
    release dut.refill_count_q;
    check("preload", 128'(refill_count), 128'(16'hFFFE));
    for (int r = 0; r < 3; r++) begin
      issue(32'h0000_C000 + 32'(16 * r), 1'b0, 32'h0, 128'h0, 1, 32'h30);
      finish_refill(16'hFFFF);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
